// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared opcodes, state encoding and watchdog limit
package instr_sequencer_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC, OP_SHL, OP_SHR,
    OP_JMP, OP_HALT = 4'hF
  } opcode_t;
  localparam logic [2:0] WDOG_LIMIT = 3'd7;
endpackage

// File: rtl/instr_sequencer_decode.sv
// instr_decode: classifies a raw opcode into ALU / jump / halt / illegal
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       is_illegal
);
  assign is_alu     = opcode <= OP_SHR;
  assign is_jmp     = opcode == OP_JMP;
  assign is_halt    = opcode == OP_HALT;
  assign is_illegal = !(is_alu || is_jmp || is_halt);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/issue sequencer with jump, halt and watchdog
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic       op,
  input  logic       ctrl_done,
  output logic [3:0] pc,
  output logic       running,
  output logic       halted,
  output logic       fault
);
  state_t     state, nxt;
  logic [2:0] wdog;
  logic       is_alu, is_jmp, is_halt, is_illegal;

  instr_decode u_dec (
    .opcode(rom_data[7:4]),
    .is_alu(is_alu),
    .is_jmp(is_jmp),
    .is_halt(is_halt),
    .is_illegal(is_illegal)
  );

  assign rom_addr = pc;

  // next state; status flags are registered from it so they line up with the state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = is_alu ? S_ISSUE : is_halt ? S_HALT : S_FETCH;
      S_ISSUE:  nxt = S_WAIT;
      S_WAIT:   nxt = ctrl_done ? S_FETCH : (wdog == WDOG_LIMIT) ? S_HALT : S_WAIT;
      S_HALT:   nxt = start ? S_FETCH : S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // state, program counter, decoded fields, watchdog and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      opcode  <= '0;
      operand <= '0;
      op      <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
      wdog    <= '0;
    end else begin
      state   <= nxt;
      op      <= nxt == S_ISSUE;
      running <= nxt inside {S_FETCH, S_DECODE, S_ISSUE, S_WAIT};
      halted  <= nxt == S_HALT;
      case (state)
        S_IDLE: if (start) pc <= '0;
        S_DECODE: begin
          opcode  <= rom_data[7:4];
          operand <= rom_data[3:0];
          if (is_jmp) pc <= rom_data[3:0];
          else if (is_illegal) begin
            fault <= 1'b1;
            pc    <= pc + 4'd1;
          end
        end
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          if (ctrl_done) pc <= pc + 4'd1;
          else begin
            wdog <= wdog + 3'd1;
            if (wdog == WDOG_LIMIT) fault <= 1'b1;
          end
        end
        S_HALT: if (start) begin
          pc    <= '0;
          fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed checks of fetch/issue, jump, halt, illegal, watchdog, wrap and reset
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rom_addr, opcode, operand, pc;
  logic [7:0] rom_data = 8'h00;
  logic       op, running, halted, fault;
  logic       done_q = 1'b0, auto_done = 1'b1, force_done = 1'b0;
  logic       ctrl_done;
  logic [7:0] rom [16];
  int         tests = 0, fails = 0;
  int         cyc = 0, nops = 0, base = 0;
  logic [7:0] log_code [64];
  int         log_cyc [64];

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .opcode(opcode), .operand(operand), .op(op), .ctrl_done(ctrl_done), .pc(pc),
    .running(running), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  assign ctrl_done = done_q | force_done;

  // synchronous program ROM and a controller answering one cycle after each op
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    done_q   <= op & auto_done;
  end

  // op pulse log with cycle stamps
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (op && nops < 64) begin
      log_code[nops] <= {opcode, operand};
      log_cyc[nops]  <= cyc;
      nops           <= nops + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(halted), 1);
  endtask

  task automatic wait_op(input string tag);
    int n = 0;
    @(negedge clk);
    while (!op && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(op), 1);
  endtask

  initial begin
    bit saw15, dropped, wrapped;
    fill_rom(8'hF0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({pc, opcode, operand, op, running, halted, fault}), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_start", int'({running, halted, op}), 0);

    // basic program with latency and issue interval
    rom[0] = 8'h03; rom[1] = 8'h25; rom[2] = 8'hF0;
    base = nops;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    chk("fetch_running", int'(running), 1);
    chk("fetch_no_op", int'(op), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("latency_op", int'(op), 1);
    chk("first_fields", int'({opcode, operand}), 8'h03);
    wait_halt("prog_halt");
    chk("prog_nops", nops - base, 2);
    chk("prog_op0", int'(log_code[base]), 8'h03);
    chk("prog_op1", int'(log_code[base+1]), 8'h25);
    chk("issue_interval", log_cyc[base+1] - log_cyc[base], 4);
    chk("prog_pc", int'(pc), 2);
    chk("prog_fault", int'(fault), 0);
    chk("prog_running", int'(running), 0);

    // jump skips op, lands on ALU op then halt
    fill_rom(8'hF0);
    rom[0] = 8'h9C; rom[12] = 8'h41; rom[13] = 8'hF0;
    base = nops;
    kick();
    wait_halt("jmp_halt");
    chk("jmp_nops", nops - base, 1);
    chk("jmp_op", int'(log_code[base]), 8'h41);
    chk("jmp_pc", int'(pc), 13);
    chk("jmp_fault", int'(fault), 0);

    // illegal opcode is a faulting NOP
    fill_rom(8'hF0);
    rom[0] = 8'hB0;
    base = nops;
    kick();
    wait_halt("ill_halt");
    chk("ill_fault", int'(fault), 1);
    chk("ill_pc", int'(pc), 1);
    chk("ill_nops", nops - base, 0);
    kick();
    chk("ill_fault_cleared", int'(fault), 0);
    chk("ill_rerun_pc", int'(pc), 0);
    wait_halt("ill_rehalt");

    // watchdog: no ctrl_done
    fill_rom(8'hF0);
    rom[0] = 8'h30;
    auto_done = 1'b0;
    kick();
    wait_op("wd_op");
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("wd_not_yet", int'(halted), 0);
    chk("wd_wait_running", int'(running), 1);
    @(posedge clk);
    @(negedge clk);
    chk("wd_halt", int'(halted), 1);
    chk("wd_fault", int'(fault), 1);
    chk("wd_pc", int'(pc), 0);

    // pc wrap with a program of ALU ops only
    fill_rom(8'h10);
    auto_done = 1'b1;
    kick();
    saw15 = 0; dropped = 0; wrapped = 0;
    for (int i = 0; i < 200 && !wrapped; i++) begin
      @(negedge clk);
      if (!running) dropped = 1;
      if (pc == 4'd15) saw15 = 1;
      else if (saw15 && pc == 4'd0) wrapped = 1;
    end
    chk("wrap_seen", int'(wrapped), 1);
    chk("wrap_running", int'(running), 1);
    chk("wrap_no_drop", int'(dropped), 0);
    chk("wrap_fault", int'(fault), 0);

    // asynchronous reset in WAIT aborts the instruction
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    fill_rom(8'hF0);
    rom[0] = 8'h37;
    auto_done = 1'b0;
    kick();
    wait_op("rst_op");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_outputs", int'({pc, opcode, operand, op, running, halted, fault}), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    @(negedge clk) reset = 1'b1;
    base = nops;
    force_done = 1'b1;
    @(negedge clk) force_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_no_op", nops - base, 0);
    chk("rst_idle", int'({running, halted, fault}), 0);
    chk("rst_pc", int'(pc), 0);
    kick();
    wait_op("rst_resume_op");
    chk("rst_resume_fields", int'({opcode, operand}), 8'h37);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
